// File: rtl/alu_pkg.sv
// Shared opcode map, helper predicates and FSM state type
// for the ALU sequencer.
package alu_pkg;

    localparam logic [4:0] ALU_ZERO       = 5'h00;
    localparam logic [4:0] ALU_PASS_A     = 5'h01;
    localparam logic [4:0] ALU_PASS_B     = 5'h02;
    localparam logic [4:0] ALU_AND        = 5'h03;
    localparam logic [4:0] ALU_OR         = 5'h04;
    localparam logic [4:0] ALU_XOR        = 5'h05;
    localparam logic [4:0] ALU_NOT_A      = 5'h06;
    localparam logic [4:0] ALU_ADD        = 5'h07;
    localparam logic [4:0] ALU_SUB        = 5'h08;
    localparam logic [4:0] ALU_INC_A      = 5'h09;
    localparam logic [4:0] ALU_DEC_A      = 5'h0A;
    localparam logic [4:0] ALU_INC_B      = 5'h0B;
    localparam logic [4:0] ALU_DEC_B      = 5'h0C;
    localparam logic [4:0] ALU_NEG_A      = 5'h0D;
    localparam logic [4:0] ALU_NEG_B      = 5'h0E;
    localparam logic [4:0] ALU_ROR_A      = 5'h0F;
    localparam logic [4:0] ALU_ROR_B      = 5'h10;
    localparam logic [4:0] ALU_ROL_A      = 5'h11;
    localparam logic [4:0] ALU_ROL_B      = 5'h12;
    localparam logic [4:0] ALU_LSR_A      = 5'h13;
    localparam logic [4:0] ALU_LSR_B      = 5'h14;
    localparam logic [4:0] ALU_LSL_A      = 5'h15;
    localparam logic [4:0] ALU_LSL_B      = 5'h16;
    localparam logic [4:0] ALU_FLAGS_READ = 5'h1F;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        RESP
    } seq_state_t;

    function automatic logic is_shift(input logic [4:0] op);
        return (op >= ALU_ROR_A) && (op <= ALU_LSL_B);
    endfunction

    // Even shift opcodes act on operand B, odd ones on A.
    function automatic logic shift_on_b(input logic [4:0] op);
        return !op[0];
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return (op <= ALU_LSL_B) || (op == ALU_FLAGS_READ);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Drives the 8-bit ALU for one requester over valid/ready
// request/response channels; iterates shift opcodes.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int          COUNT_W      = 3,
    parameter logic [7:0]  ILLEGAL_DATA = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [4:0]         req_op,
    input  logic [7:0]         req_a,
    input  logic [7:0]         req_b,
    input  logic [COUNT_W-1:0] req_count,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [7:0]         rsp_data,
    output logic [4:0]         rsp_flags,
    output logic               rsp_err,
    output logic [4:0]         alu_opcode,
    output logic [7:0]         alu_reg_a,
    output logic [7:0]         alu_reg_b,
    output logic               alu_out_n,
    output logic               reg_f_out_n,
    output logic               reg_f_load,
    input  logic [7:0]         alu_data,
    input  logic [7:0]         alu_flags
);

    seq_state_t         state_q, state_d;
    logic [4:0]         op_q, op_d;
    logic [7:0]         a_q, a_d;
    logic [7:0]         b_q, b_d;
    logic [COUNT_W-1:0] iter_q, iter_d;
    logic [7:0]         data_q, data_d;
    logic [4:0]         flags_q, flags_d;
    logic               err_q, err_d;
    logic               last;
    logic               unused_flags;

    assign last         = (iter_q == COUNT_W'(1));
    assign unused_flags = ^alu_flags[7:5];

    assign alu_opcode = op_q;
    assign alu_reg_a  = a_q;
    assign alu_reg_b  = b_q;
    assign rsp_data   = data_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        iter_d      = iter_q;
        data_d      = data_q;
        flags_d     = flags_q;
        err_d       = err_q;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        alu_out_n   = 1'b1;
        reg_f_out_n = 1'b1;
        reg_f_load  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && is_legal(req_op)) begin
                    op_d   = req_op;
                    a_d    = req_a;
                    b_d    = req_b;
                    iter_d = COUNT_W'(1);
                    if (is_shift(req_op) && req_count != '0)
                        iter_d = req_count;
                    err_d   = 1'b0;
                    state_d = EXEC;
                end else if (req_valid) begin
                    // ALU bus is left untouched for illegal ops.
                    err_d   = 1'b1;
                    data_d  = ILLEGAL_DATA;
                    state_d = RESP;
                end
            end
            EXEC: begin
                data_d = alu_data;
                if (op_q == ALU_FLAGS_READ) begin
                    reg_f_out_n = 1'b0;
                    state_d     = CAPT;
                end else begin
                    alu_out_n  = 1'b0;
                    reg_f_load = last;
                    iter_d     = iter_q - COUNT_W'(1);
                    if (is_shift(op_q) && shift_on_b(op_q))
                        b_d = alu_data;
                    else if (is_shift(op_q))
                        a_d = alu_data;
                    if (last)
                        state_d = CAPT;
                end
            end
            CAPT: begin
                flags_d = alu_flags[4:0];
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            iter_q  <= '0;
            data_q  <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            iter_q  <= iter_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer wired to a behavioural 8-bit ALU
// with a flags latch loaded by reg_f_load.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [4:0] req_op = '0;
    logic [7:0] req_a = '0;
    logic [7:0] req_b = '0;
    logic [2:0] req_count = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [4:0] rsp_flags;
    logic       rsp_err;
    logic [4:0] alu_opcode;
    logic [7:0] alu_reg_a;
    logic [7:0] alu_reg_b;
    logic       alu_out_n;
    logic       reg_f_out_n;
    logic       reg_f_load;
    logic [7:0] alu_data;
    logic [7:0] alu_flags;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_sequencer #(
        .COUNT_W(3),
        .ILLEGAL_DATA(8'h00)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_a(req_a),
        .req_b(req_b),
        .req_count(req_count),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_flags(rsp_flags),
        .rsp_err(rsp_err),
        .alu_opcode(alu_opcode),
        .alu_reg_a(alu_reg_a),
        .alu_reg_b(alu_reg_b),
        .alu_out_n(alu_out_n),
        .reg_f_out_n(reg_f_out_n),
        .reg_f_load(reg_f_load),
        .alu_data(alu_data),
        .alu_flags(alu_flags)
    );

    // Behavioural ALU: result {ovf, carry, data}.
    logic [9:0] alu_t;
    logic [7:0] sx;
    logic [4:0] fl_calc;
    logic [4:0] flag_lat = '0;

    function automatic logic [9:0] addc(input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic ci);
        logic [8:0] s;
        s = {1'b0, x} + {1'b0, y} + {8'b0, ci};
        return {(x[7] == y[7]) && (s[7] != x[7]), s[8], s[7:0]};
    endfunction

    always_comb begin
        alu_t = '0;
        sx = alu_opcode[0] ? alu_reg_a : alu_reg_b;
        case (alu_opcode)
            5'h01: alu_t = {2'b00, alu_reg_a};
            5'h02: alu_t = {2'b00, alu_reg_b};
            5'h03: alu_t = {2'b00, alu_reg_a & alu_reg_b};
            5'h04: alu_t = {2'b00, alu_reg_a | alu_reg_b};
            5'h05: alu_t = {2'b00, alu_reg_a ^ alu_reg_b};
            5'h06: alu_t = {2'b00, ~alu_reg_a};
            5'h07: alu_t = addc(alu_reg_a, alu_reg_b, 1'b0);
            5'h08: alu_t = addc(alu_reg_a, ~alu_reg_b, 1'b1);
            5'h09: alu_t = addc(alu_reg_a, 8'h00, 1'b1);
            5'h0A: alu_t = addc(alu_reg_a, 8'hFF, 1'b0);
            5'h0B: alu_t = addc(alu_reg_b, 8'h00, 1'b1);
            5'h0C: alu_t = addc(alu_reg_b, 8'hFF, 1'b0);
            5'h0D: alu_t = addc(8'h00, ~alu_reg_a, 1'b1);
            5'h0E: alu_t = addc(8'h00, ~alu_reg_b, 1'b1);
            5'h0F, 5'h10: alu_t = {1'b0, sx[0], sx[0], sx[7:1]};
            5'h11, 5'h12: alu_t = {1'b0, sx[7], sx[6:0], sx[7]};
            5'h13, 5'h14: alu_t = {1'b0, sx[0], 1'b0, sx[7:1]};
            5'h15, 5'h16: alu_t = {1'b0, sx[7], sx[6:0], 1'b0};
            default: alu_t = '0;
        endcase
        fl_calc = {alu_t[9], alu_t[8], |alu_t[7:0], alu_t[0], alu_t[7]};
    end

    // Latch closes at the edge ending the reg_f_load cycle.
    always @(posedge clk)
        if (reg_f_load) flag_lat <= fl_calc;

    assign alu_data  = !alu_out_n   ? alu_t[7:0] :
                       !reg_f_out_n ? {3'b000, flag_lat} : 8'h00;
    assign alu_flags = {3'b000, flag_lat};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic run(input string tag,
                       input logic [4:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [2:0] cnt,
                       input logic [7:0] ed,
                       input logic [4:0] ef,
                       input logic ee,
                       input int elat,
                       input int hold,
                       input int eload,
                       input int efout,
                       input int eaout);
        int cyc, nload, nfout, naout, nboth, bad;
        nload = 0; nfout = 0; naout = 0; nboth = 0; bad = 0;
        @(negedge clk);
        chk({tag, ".rdy"}, req_ready, 1);
        req_op = op; req_a = a; req_b = b; req_count = cnt;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        forever begin
            if (reg_f_load) nload++;
            if (!reg_f_out_n) nfout++;
            if (!alu_out_n) naout++;
            if (!reg_f_out_n && !alu_out_n) nboth++;
            if (rsp_valid || cyc >= 20) break;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".lat"}, cyc, elat);
        chk({tag, ".data"}, rsp_data, ed);
        chk({tag, ".flags"}, rsp_flags, ef);
        chk({tag, ".err"}, rsp_err, ee);
        chk({tag, ".fload"}, nload, eload);
        chk({tag, ".fout"}, nfout, efout);
        chk({tag, ".aout"}, naout, eaout);
        chk({tag, ".both"}, nboth, 0);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                if (!rsp_valid || req_ready || rsp_data !== ed ||
                    rsp_flags !== ef || rsp_err !== ee)
                    bad++;
            end
            chk({tag, ".hold"}, bad, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, ".ret"}, {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.strobes",
            {req_ready, rsp_valid, alu_out_n, reg_f_out_n, reg_f_load},
            5'b10110);
        chk("rst.rsp", {rsp_data, rsp_flags, rsp_err}, 14'h0);
        chk("rst.alu", {alu_opcode, alu_reg_a, alu_reg_b}, 21'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run("add",  5'h07, 8'h7F, 8'h01, 3'd0, 8'h80, 5'h15, 1'b0, 3, 0, 1, 0, 1);
        run("frd1", 5'h1F, 8'h00, 8'h00, 3'd0, 8'h15, 5'h15, 1'b0, 3, 0, 0, 1, 0);
        run("ill",  5'h18, 8'h12, 8'h34, 3'd0, 8'h00, 5'h15, 1'b1, 1, 4, 0, 0, 0);
        run("frd2", 5'h1F, 8'h00, 8'h00, 3'd0, 8'h15, 5'h15, 1'b0, 3, 0, 0, 1, 0);
        run("sub",  5'h08, 8'h05, 8'h05, 3'd0, 8'h00, 5'h08, 1'b0, 3, 0, 1, 0, 1);
        run("lsra", 5'h13, 8'h80, 8'h00, 3'd3, 8'h10, 5'h04, 1'b0, 5, 4, 1, 0, 3);
        run("lslb", 5'h16, 8'h00, 8'h81, 3'd0, 8'h02, 5'h0C, 1'b0, 3, 0, 1, 0, 1);
        run("and",  5'h03, 8'hF0, 8'h3C, 3'd5, 8'h30, 5'h04, 1'b0, 3, 0, 1, 0, 1);
        run("rola", 5'h11, 8'h81, 8'h00, 3'd7, 8'hC0, 5'h05, 1'b0, 9, 0, 1, 0, 7);

        @(negedge clk);
        req_op = 5'h13; req_a = 8'h80; req_b = 8'h00; req_count = 3'd7;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid.exec", alu_out_n, 0);
        rst_n = 1'b0;
        #1;
        chk("mid.strobes",
            {req_ready, rsp_valid, alu_out_n, reg_f_out_n, reg_f_load},
            5'b10110);
        chk("mid.rsp", {rsp_data, rsp_flags, rsp_err}, 14'h0);
        chk("mid.alu", {alu_opcode, alu_reg_a, alu_reg_b}, 21'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("mid.norsp", seen, 0);

        run("add2", 5'h07, 8'h01, 8'hFF, 3'd0, 8'h00, 5'h08, 1'b0, 3, 0, 1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
